// File: rtl/matmul2x2_seq.sv
// matmul2x2_seq: sequential 2x2 matrix multiply, one shared MAC per cycle.
// Operands are snapshotted on the active rising edge; C is held for display.
module matmul2x2_seq #(
  parameter int W  = 4,
  parameter int CW = 2*W+1
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic [W-1:0]  A00,
  input  logic [W-1:0]  A01,
  input  logic [W-1:0]  A10,
  input  logic [W-1:0]  A11,
  input  logic [W-1:0]  B00,
  input  logic [W-1:0]  B01,
  input  logic [W-1:0]  B10,
  input  logic [W-1:0]  B11,
  input  logic          active,
  input  logic          clear,
  output logic [CW-1:0] C00,
  output logic [CW-1:0] C01,
  output logic [CW-1:0] C10,
  output logic [CW-1:0] C11,
  output logic          busy,
  output logic          valid,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      step_q;
  logic [2:0]      step_d;
  logic [2*W-1:0]  acc_q;
  logic            active_q;
  logic [W-1:0]    a_q [4];
  logic [W-1:0]    b_q [4];
  logic [CW-1:0]   c_q [4];
  logic            busy_q;
  logic            valid_q;
  logic            done_q;

  logic            start;
  logic            row;
  logic            col;
  logic            t;
  logic [1:0]      elem;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [2*W-1:0]  prod;
  logic [CW-1:0]   sum_d;

  // Operand select and the single shared multiplier for the current step.
  always_comb begin
    start  = active & ~active_q;
    row    = step_q[2];
    col    = step_q[1];
    t      = step_q[0];
    elem   = step_q[2:1];
    op_a   = a_q[{row, t}];
    op_b   = b_q[{t, col}];
    prod   = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    sum_d  = CW'(acc_q) + CW'(prod);
    step_d = step_q + 3'd1;
  end

  // Control FSM, MAC datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      acc_q    <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      active_q <= active;
      done_q   <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        step_q  <= 3'd0;
        acc_q   <= '0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          c_q[i] <= '0;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              a_q[0]  <= A00;
              a_q[1]  <= A01;
              a_q[2]  <= A10;
              a_q[3]  <= A11;
              b_q[0]  <= B00;
              b_q[1]  <= B01;
              b_q[2]  <= B10;
              b_q[3]  <= B11;
              step_q  <= 3'd0;
              state_q <= MUL;
              busy_q  <= 1'b1;
            end
          end
          MUL: begin
            if (!t) begin
              acc_q <= prod;
            end else begin
              c_q[elem] <= sum_d;
            end
            if (step_q == 3'd7) begin
              step_q  <= 3'd0;
              state_q <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              step_q <= step_d;
            end
          end
          DONE: begin
            if (!active) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign C00   = c_q[0];
  assign C01   = c_q[1];
  assign C10   = c_q[2];
  assign C11   = c_q[3];
  assign busy  = busy_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule
